iic_reg_config: RTL and testbench

// - Register-init sequencer that sits directly upstream of iic_interface and drives its start/wr_rd/addr/din/iic_main inputs.
// - Walks an external ROM of {reg_addr, reg_data} entries and issues one IIC write per entry.
// - Retries NACKed transfers, supports in-table delays and end-of-table markers, and reports done/error.
// - Used once at power-up for OV7670 camera and ADV7511 HDMI init.

---
 rtl/iic_reg_config.sv | 255 +++++++++++++++++++++++++
 tb/tb_iic_reg_config.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/iic_reg_config.sv
// iic_reg_config: power-up register-init sequencer feeding iic_interface.
// Walks a registered ROM of {reg_addr, reg_data} entries and issues one IIC
// write per entry, with NACK/timeout retries, in-table ms delays (FExx) and
// an end marker (FFFF).
// Optional feature macro: IIC_CFG_VERIFY_EN (read back and compare every write).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_go rising edge (auto-start once after reset)
// PWRUP   | power-up settle time before the first transfer
// MAIN    | set up the bus-switch (iic_main) transfer
// FETCH   | present ROM address, decode the entry on the second cycle
// ISSUE   | one setup cycle, then o_iic_start high for two cycles
// WAIT    | wait for i_iic_finish or timeout
// GAP     | idle time between transfers (also before a retry)
// DELAY   | in-table delay, xx milliseconds
// DONE    | table completed, waiting for i_go
// ERROR   | retries exhausted, waiting for i_go
module iic_reg_config #(
  parameter int ROM_AW      = 8,
  parameter int PWRUP_CYC   = 650000,
  parameter int GAP_CYC     = 6480,
  parameter int MS_CYC      = 64796,
  parameter int RETRY_MAX   = 3,
  parameter int TIMEOUT_CYC = 200000,
  parameter int USE_MAIN    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_go,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ROM_AW-1:0] o_err_index,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_iic_start,
  output logic              o_iic_wr_rd_en,
  output logic [7:0]        o_iic_addr,
  output logic [7:0]        o_iic_din,
  output logic              o_iic_main,
  input  logic              i_iic_finish,
  input  logic              i_iic_no_ack,
  input  logic              i_iic_dout_en,
  input  logic [7:0]        i_iic_dout
);

  localparam int M1      = (PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC;
  localparam int M2      = (MS_CYC > TIMEOUT_CYC) ? MS_CYC : TIMEOUT_CYC;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CW      = $clog2(CNT_MAX + 4);
  localparam int RW      = $clog2(RETRY_MAX + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_MAIN, S_FETCH, S_ISSUE,
    S_WAIT, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_ld_val;
  logic [ROM_AW-1:0] idx, err_index;
  logic [RW-1:0]     retry_cnt;
  logic [7:0]        ms_left, iic_addr, iic_din;
  logic              go_q, go_pend, main_phase, gap_to_issue;
  logic              go_rise, cnt_zero, idx_last, rom_end, rom_dly, retry_left;
  logic              xfer_ok, xfer_fail, rd_match, need_read, wr_rd;

  assign go_rise    = i_go & ~go_q;
  assign cnt_zero   = (cnt == '0);
  assign idx_last   = &idx;
  assign rom_end    = (i_rom_data == 16'hFFFF);
  assign rom_dly    = (i_rom_data[15:8] == 8'hFE);
  assign retry_left = (retry_cnt < RW'(RETRY_MAX));
  assign xfer_ok    = i_iic_finish & ~i_iic_no_ack & rd_match;
  assign xfer_fail  = (i_iic_finish & ~xfer_ok) | (~i_iic_finish & cnt_zero);

`ifdef IIC_CFG_VERIFY_EN
  logic       rd_phase, rd_seen;
  logic [7:0] rd_data;

  // Alternate write/read-back phases of an entry and capture read data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_phase <= 1'b0;
      rd_seen  <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (state_nxt == S_PWRUP && state != S_PWRUP)
        rd_phase <= 1'b0;
      else if (state == S_WAIT && xfer_ok)
        rd_phase <= ~rd_phase & ~main_phase;
      else if (state == S_WAIT && xfer_fail)
        rd_phase <= 1'b0;
      if (state == S_ISSUE)
        rd_seen <= 1'b0;
      else if (state == S_WAIT && i_iic_dout_en) begin
        rd_seen <= 1'b1;
        rd_data <= i_iic_dout;
      end
    end
  end

  assign rd_match  = ~rd_phase | (i_iic_dout_en ? (i_iic_dout == iic_din)
                                                : (rd_seen && rd_data == iic_din));
  assign need_read = ~rd_phase & ~main_phase;
  assign wr_rd     = rd_phase;
`else
  logic unused_rd;
  assign unused_rd = ^{i_iic_dout_en, i_iic_dout};
  assign rd_match  = 1'b1;
  assign need_read = 1'b0;
  assign wr_rd     = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go_pend || go_rise) state_nxt = S_PWRUP;
      S_PWRUP: if (cnt_zero) state_nxt = (USE_MAIN != 0) ? S_MAIN : S_FETCH;
      S_MAIN:  state_nxt = S_ISSUE;
      S_FETCH: if (cnt_zero) begin
        if (rom_end)                     state_nxt = S_DONE;
        else if (!rom_dly)               state_nxt = S_ISSUE;
        else if (i_rom_data[7:0] != '0)  state_nxt = S_DELAY;
        else if (idx_last)               state_nxt = S_DONE;
        else                             state_nxt = S_FETCH;
      end
      S_ISSUE: if (cnt_zero) state_nxt = S_WAIT;
      S_WAIT: begin
        if (xfer_ok)
          state_nxt = (idx_last && !main_phase && !need_read) ? S_DONE : S_GAP;
        else if (xfer_fail)
          state_nxt = retry_left ? S_GAP : S_ERROR;
      end
      S_GAP:   if (cnt_zero) state_nxt = gap_to_issue ? S_ISSUE : S_FETCH;
      S_DELAY: if (cnt_zero && ms_left <= 8'd1) state_nxt = idx_last ? S_DONE : S_FETCH;
      S_DONE, S_ERROR: if (go_rise) state_nxt = S_PWRUP;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Down-counter reload value for the state being entered
  always_comb begin
    cnt_ld_val = '0;
    case (state_nxt)
      S_PWRUP: cnt_ld_val = CW'(PWRUP_CYC - 1);
      S_FETCH: cnt_ld_val = CW'(1);
      S_ISSUE: cnt_ld_val = CW'(2);
      S_WAIT:  cnt_ld_val = CW'(TIMEOUT_CYC - 1);
      S_GAP:   cnt_ld_val = CW'(GAP_CYC - 1);
      S_DELAY: cnt_ld_val = CW'(MS_CYC - 1);
      default: cnt_ld_val = '0;
    endcase
  end

  // Shared down-counter; FETCH and DELAY can re-enter themselves, so reload there too
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt <= '0;
    else if (state_nxt != state || ((state == S_FETCH || state == S_DELAY) && cnt_zero))
      cnt <= cnt_ld_val;
    else if (!cnt_zero)
      cnt <= cnt - CW'(1);
  end

  // Table index, retry bookkeeping and transfer fields
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      go_q         <= 1'b0;
      go_pend      <= 1'b1;
      idx          <= '0;
      err_index    <= '0;
      retry_cnt    <= '0;
      ms_left      <= '0;
      iic_addr     <= '0;
      iic_din      <= '0;
      main_phase   <= 1'b0;
      gap_to_issue <= 1'b0;
    end else begin
      go_q <= i_go;
      if (state_nxt == S_PWRUP && state != S_PWRUP) begin
        go_pend      <= 1'b0;
        idx          <= '0;
        retry_cnt    <= '0;
        main_phase   <= 1'b0;
        gap_to_issue <= 1'b0;
      end
      case (state)
        S_MAIN: begin
          main_phase <= 1'b1;
          iic_addr   <= '0;
          iic_din    <= '0;
        end
        S_FETCH: if (cnt_zero && !rom_end) begin
          if (rom_dly) begin
            ms_left <= i_rom_data[7:0];
            if (i_rom_data[7:0] == '0) idx <= idx + ROM_AW'(1);
          end else begin
            iic_addr <= i_rom_data[15:8];
            iic_din  <= i_rom_data[7:0];
          end
        end
        S_WAIT: begin
          if (xfer_ok) begin
            retry_cnt <= '0;
            if (main_phase) begin
              main_phase   <= 1'b0;
              gap_to_issue <= 1'b0;
            end else if (need_read) begin
              gap_to_issue <= 1'b1;
            end else begin
              idx          <= idx + ROM_AW'(1);
              gap_to_issue <= 1'b0;
            end
          end else if (xfer_fail) begin
            if (retry_left) begin
              retry_cnt    <= retry_cnt + RW'(1);
              gap_to_issue <= 1'b1;
            end else begin
              err_index  <= idx;
              main_phase <= 1'b0;
            end
          end
        end
        S_DELAY: if (cnt_zero) begin
          if (ms_left <= 8'd1) idx <= idx + ROM_AW'(1);
          else                 ms_left <= ms_left - 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    o_busy         = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
    o_done         = (state == S_DONE);
    o_error        = (state == S_ERROR);
    o_err_index    = err_index;
    o_rom_addr     = idx;
    o_iic_start    = (state == S_ISSUE) && (cnt != CW'(2));
    o_iic_wr_rd_en = wr_rd;
    o_iic_addr     = iic_addr;
    o_iic_din      = iic_din;
    o_iic_main     = main_phase;
  end

endmodule

// File: tb/tb_iic_reg_config.sv
// Testbench for iic_reg_config: registered ROM model, IIC responder with
// scripted NACKs / random latency, and a table-level reference model of the
// expected write sequence and final status.
module tb_iic_reg_config;

  localparam int AW     = 4;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic          busy, done, error, start, wr_rd, main;
  logic [AW-1:0] err_index, rom_addr;
  logic [15:0]   rom_q;
  logic [7:0]    addr, din;
  logic          finish = 1'b0;
  logic          no_ack = 1'b0;
  logic          dout_en = 1'b0;
  logic [7:0]    dout = 8'h00;

  always #5 clk = ~clk;

  iic_reg_config #(
    .ROM_AW(AW), .PWRUP_CYC(100), .GAP_CYC(10), .MS_CYC(20),
    .RETRY_MAX(3), .TIMEOUT_CYC(300), .USE_MAIN(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go),
    .o_busy(busy), .o_done(done), .o_error(error), .o_err_index(err_index),
    .o_rom_addr(rom_addr), .i_rom_data(rom_q),
    .o_iic_start(start), .o_iic_wr_rd_en(wr_rd), .o_iic_addr(addr),
    .o_iic_din(din), .o_iic_main(main),
    .i_iic_finish(finish), .i_iic_no_ack(no_ack),
    .i_iic_dout_en(dout_en), .i_iic_dout(dout)
  );

  logic [15:0] rom [16];
  always @(posedge clk) rom_q <= rom[rom_addr];

  int          compared = 0;
  int          mismatched = 0;
  int          mode = 0;        // 0: finishes normally, 1: never finishes
  bit          stray_en = 0;
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  bit          nack_q[$];
  int          cyc = 0;
  int          first_start = -1;
  bit          start_seen = 0;
  bit          pending = 0;
  int          lat = 0;

  // IIC responder: records each transfer, answers after random latency
  always @(negedge clk) begin
    if (!rst_n) begin
      finish = 1'b0; no_ack = 1'b0; pending = 0; start_seen = 0; cyc = 0;
    end else begin
      finish = 1'b0; no_ack = 1'b0; cyc++;
      if (start && !start_seen) begin
        start_seen = 1;
        got.push_back({main, wr_rd, addr, din});
        if (first_start < 0) first_start = cyc;
        if (mode == 0) begin pending = 1; lat = $urandom_range(2, 15); end
        if (stray_en) finish = 1'b1;   // lands in ISSUE, must be ignored
      end else if (!start) begin
        start_seen = 0;
      end
      if (pending) begin
        if (lat == 0) begin
          finish = 1'b1;
          no_ack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
          pending = 0;
        end else lat--;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [17:0] wr(input logic [15:0] e);
    return {2'b00, e};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic start_run();
    rst_n = 1'b0;
    got.delete();
    first_start = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || error) && n < BUDGET) begin @(negedge clk); n++; end
    check({tag, "_finished"}, {31'b0, done | error}, 32'd1);
  endtask

  task automatic check_run(input string tag, input bit exp_done, input int exp_idx);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check({tag, "_xfer"}, {14'b0, got[i]}, {14'b0, exp_q[i]});
    check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check({tag, "_error"}, {31'b0, error}, {31'b0, ~exp_done});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    if (!exp_done) check({tag, "_err_index"}, {28'b0, err_index}, exp_idx);
  endtask

  initial begin
    int t0, t1, n, k, r, exp_err;
    logic [15:0] e;

    clear_rom();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, error, start, wr_rd, main, addr, din, err_index, rom_addr},
          32'd0);

    // Two plain writes, always ACKed
    rom[0] = 16'h1280; rom[1] = 16'h12A5;
    nack_q.delete();
    start_run();
    wait_end("basic");
    exp_q = '{wr(16'h1280), wr(16'h12A5)};
    check_run("basic", 1, 0);

    // FE00 (no delay) vs FE03 (3 ms): first start shifts by exactly 3*MS_CYC
    clear_rom(); rom[0] = 16'hFE00; rom[1] = 16'h3A04;
    start_run(); wait_end("nodelay");
    t0 = first_start;
    rom[0] = 16'hFE03;
    start_run(); wait_end("delay");
    t1 = first_start;
    check("delay_cycles", t1 - t0, 32'd60);
    exp_q = '{wr(16'h3A04)};
    check_run("delay", 1, 0);

    // Entry 1 NACKed twice, then ACKed
    clear_rom(); rom[0] = 16'h1280; rom[1] = 16'h12A5;
    nack_q = '{1'b0, 1'b1, 1'b1, 1'b0};
    start_run(); wait_end("nack2");
    exp_q = '{wr(16'h1280), wr(16'h12A5), wr(16'h12A5), wr(16'h12A5)};
    check_run("nack2", 1, 0);

    // Always NACK: four attempts on entry 0, then ERROR
    nack_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    start_run(); wait_end("nack_all");
    exp_q = '{wr(16'h1280), wr(16'h1280), wr(16'h1280), wr(16'h1280)};
    check_run("nack_all", 0, 0);

    // i_go from ERROR clears the error and reruns the table
    nack_q.delete(); got.delete();
    go = 1'b1;
    @(negedge clk);
    check("go_clears_error", {30'b0, error, busy}, 32'd1);
    go = 1'b0;
    wait_end("restart");
    exp_q = '{wr(16'h1280), wr(16'h12A5)};
    check_run("restart", 1, 0);

    // Retries exhausted on a non-zero index
    nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    start_run(); wait_end("err_idx1");
    exp_q = '{wr(16'h1280), wr(16'h12A5), wr(16'h12A5), wr(16'h12A5), wr(16'h12A5)};
    check_run("err_idx1", 0, 1);

    // Responder never finishes: timeout path, four attempts, ERROR
    mode = 1; nack_q.delete();
    start_run(); wait_end("timeout");
    exp_q = '{wr(16'h1280), wr(16'h1280), wr(16'h1280), wr(16'h1280)};
    check_run("timeout", 0, 0);
    mode = 0;

    // Full table with no end marker: last index executes, then DONE
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      rom[i] = {8'(i + 8'h20), 8'(i * 7)};
      exp_q.push_back(wr(rom[i]));
    end
    start_run(); wait_end("wrap");
    check_run("wrap", 1, 0);

    // Random tables and NACK patterns against the table-level model
    stray_en = 1;
    for (int it = 0; it < 5; it++) begin
      clear_rom(); nack_q.delete(); exp_q.delete();
      n = $urandom_range(2, 8);
      exp_err = -1;
      for (int i = 0; i < n; i++) begin
        e = {8'($urandom_range(0, 253)), 8'($urandom_range(0, 255))};
        rom[i] = e;
        r = $urandom_range(0, 9);
        k = (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 3 : 4;
        if (exp_err < 0) begin
          for (int a = 0; a < k; a++) nack_q.push_back(1'b1);
          if (k < 4) nack_q.push_back(1'b0);
          for (int a = 0; a < ((k == 4) ? 4 : k + 1); a++) exp_q.push_back(wr(e));
          if (k == 4) exp_err = i;
        end
      end
      start_run(); wait_end("random");
      check_run("random", (exp_err < 0), (exp_err < 0) ? 0 : exp_err);
    end
    stray_en = 0;

    // Reset in the middle of WAIT: everything drops to zero
    clear_rom(); rom[0] = 16'h1280;
    mode = 1;
    start_run();
    n = 0;
    while (!(got.size() >= 1 && !start) && n < BUDGET) begin @(negedge clk); n++; end
    check("reached_wait", {31'b0, (got.size() >= 1) && busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_wait", {busy, done, error, start, wr_rd, main, addr, din, err_index, rom_addr},
          32'd0);
    mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
